// File: rtl/pong_engine.sv
// Two-player Pong core: paddles, ball physics, scoring, match FSM and pixel colour.
// Game state steps once per frame tick (x==0,y==0); rgb is 1 cycle behind x/y; no backpressure.
module pong_engine #(
    parameter int H_ACTIVE     = 640,
    parameter int V_ACTIVE     = 480,
    parameter int TOP          = 40,
    parameter int BOT          = 440,
    parameter int L_BOUND      = 60,
    parameter int R_BOUND      = 580,
    parameter int BAR_W        = 5,
    parameter int BAR_H        = 60,
    parameter int BAR_H_WIDE   = 150,
    parameter int BALL_R       = 5,
    parameter int BAR_V        = 2,
    parameter int BALL_V0      = 1,
    parameter int BALL_VMAX    = 4,
    parameter int WIN_SCORE    = 9,
    parameter int SERVE_FRAMES = 60,
    parameter int POINT_FRAMES = 30
) (
    input  logic        clk,
    input  logic        rst_n,
    input  logic [10:0] x,
    input  logic [10:0] y,
    input  logic [1:0]  btn1,
    input  logic [1:0]  btn2,
    input  logic        start,
    input  logic        wide_mode,
    output logic [7:0]  rgb,
    output logic [5:0]  lscore,
    output logic [5:0]  rscore,
    output logic        game_over
);

    typedef enum logic [2:0] {
        IDLE  = 3'd0,
        SERVE = 3'd1,
        PLAY  = 3'd2,
        POINT = 3'd3,
        OVER  = 3'd4
    } state_t;

    localparam logic signed [11:0] S_TOP  = 12'(TOP);
    localparam logic signed [11:0] S_BOT  = 12'(BOT);
    localparam logic signed [11:0] S_R    = 12'(BALL_R);
    localparam logic signed [11:0] S_LB   = 12'(L_BOUND);
    localparam logic signed [11:0] S_RB   = 12'(R_BOUND);
    localparam logic signed [11:0] S_LF   = 12'(L_BOUND + BAR_W);
    localparam logic signed [11:0] S_RF   = 12'(R_BOUND - BAR_W);
    localparam logic signed [11:0] S_XMAX = 12'(H_ACTIVE - 1);
    localparam logic signed [11:0] S_CX   = 12'(H_ACTIVE / 2);
    localparam logic signed [11:0] S_CY   = 12'(V_ACTIVE / 2);
    localparam logic signed [11:0] S_BARV = 12'(BAR_V);
    localparam logic signed [11:0] S_HN   = 12'(BAR_H / 2);
    localparam logic signed [11:0] S_HW   = 12'(BAR_H_WIDE / 2);

    localparam logic [10:0] U_HA   = 11'(H_ACTIVE);
    localparam logic [10:0] U_VA   = 11'(V_ACTIVE);
    localparam logic [10:0] U_TOP  = 11'(TOP);
    localparam logic [10:0] U_BOT  = 11'(BOT);
    localparam logic [10:0] U_LB   = 11'(L_BOUND);
    localparam logic [10:0] U_RB   = 11'(R_BOUND);
    localparam logic [10:0] PIP_R0 = 11'(H_ACTIVE - 20);
    localparam logic [10:0] PIP_R1 = 11'(H_ACTIVE - 10);

    localparam logic [2:0] V0   = 3'(BALL_V0);
    localparam logic [2:0] VMAX = 3'(BALL_VMAX);
    localparam logic [5:0] WIN  = 6'(WIN_SCORE);
    localparam logic [7:0] N_SERVE = 8'(SERVE_FRAMES);
    localparam logic [7:0] N_POINT = 8'(POINT_FRAMES);

    localparam logic [7:0] C_BG    = 8'b01001000;
    localparam logic [7:0] C_WALL  = 8'b11100001;
    localparam logic [7:0] C_LEFT  = 8'b10010111;
    localparam logic [7:0] C_RIGHT = 8'b00101011;
    localparam logic [7:0] C_BALL  = 8'b11011101;

    state_t            state, state_nxt;
    logic [7:0]        cnt, cnt_nxt;
    logic signed [11:0] ball_x, ball_y, bx_nxt, by_nxt;
    logic signed [11:0] lbar_y, rbar_y, lbar_nxt, rbar_nxt;
    logic              dir_x, dir_y, dx_nxt, dy_nxt;   // 1 = left / up
    logic [2:0]        speed, speed_nxt;
    logic              serve_left, serve_left_nxt;
    logic [5:0]        lscore_nxt, rscore_nxt;

    logic              tick, paddles_live, hit_l, hit_r;
    logic signed [11:0] half_h, reach, step, nx, ny, dl, dr, xs, ys;
    logic [10:0]       y_div10, y_div20;
    logic [7:0]        pix;

    function automatic logic signed [11:0] move_bar(input logic signed [11:0] pos,
                                                    input logic [1:0] btn,
                                                    input logic live,
                                                    input logic signed [11:0] half);
        logic signed [11:0] p;
        p = pos;
        if (live && btn == 2'b01)
            p = pos - S_BARV;
        else if (live && btn == 2'b10)
            p = pos + S_BARV;
        if (p < S_TOP + half)
            p = S_TOP + half;
        else if (p > S_BOT - half)
            p = S_BOT - half;
        return p;
    endfunction

    function automatic logic signed [11:0] abs12(input logic signed [11:0] v);
        return v[11] ? -v : v;
    endfunction

    function automatic logic [5:0] sat_inc(input logic [5:0] s);
        return (s == 6'd63) ? s : s + 6'd1;
    endfunction

    assign tick         = (x == 11'd0) && (y == 11'd0);
    assign half_h       = wide_mode ? S_HW : S_HN;
    assign reach        = half_h + S_R;
    assign step         = signed'({9'd0, speed});
    assign nx           = dir_x ? ball_x - step : ball_x + step;
    assign ny           = dir_y ? ball_y - step : ball_y + step;
    assign dr           = abs12(ny - rbar_y);
    assign dl           = abs12(ny - lbar_y);
    assign hit_r        = !dir_x && (ball_x + S_R <= S_RF) && (nx + S_R > S_RF) && (dr <= reach);
    assign hit_l        = dir_x && (ball_x - S_R >= S_LF) && (nx - S_R < S_LF) && (dl <= reach);
    assign paddles_live = (state == SERVE) || (state == PLAY);
    assign game_over    = (state == OVER);

    always_comb begin
        state_nxt      = state;
        cnt_nxt        = cnt;
        bx_nxt         = ball_x;
        by_nxt         = ball_y;
        dx_nxt         = dir_x;
        dy_nxt         = dir_y;
        speed_nxt      = speed;
        serve_left_nxt = serve_left;
        lscore_nxt     = lscore;
        rscore_nxt     = rscore;
        lbar_nxt       = tick ? move_bar(lbar_y, btn1, paddles_live, half_h) : lbar_y;
        rbar_nxt       = tick ? move_bar(rbar_y, btn2, paddles_live, half_h) : rbar_y;

        case (state)
            IDLE: begin
                bx_nxt = S_CX;
                by_nxt = S_CY;
                if (tick && start) begin
                    state_nxt = SERVE;
                    cnt_nxt   = N_SERVE;
                end
            end
            SERVE: begin
                if (tick) begin
                    if (cnt <= 8'd1) begin
                        state_nxt = PLAY;
                        cnt_nxt   = 8'd0;
                    end else begin
                        cnt_nxt = cnt - 8'd1;
                    end
                end
            end
            PLAY: begin
                if (tick) begin
                    bx_nxt = nx;
                    by_nxt = ny;
                    if (ny - S_R <= S_TOP) begin
                        by_nxt = S_TOP + S_R;
                        dy_nxt = 1'b0;
                    end else if (ny + S_R >= S_BOT) begin
                        by_nxt = S_BOT - S_R;
                        dy_nxt = 1'b1;
                    end
                    // A paddle hit wins over the miss test: the ball is placed back on the face.
                    if (hit_r) begin
                        bx_nxt    = S_RF - S_R;
                        dx_nxt    = 1'b1;
                        speed_nxt = (speed >= VMAX) ? VMAX : speed + 3'd1;
                    end else if (hit_l) begin
                        bx_nxt    = S_LF + S_R;
                        dx_nxt    = 1'b0;
                        speed_nxt = (speed >= VMAX) ? VMAX : speed + 3'd1;
                    end else if (nx - S_R < 12'sd0) begin
                        rscore_nxt     = sat_inc(rscore);
                        serve_left_nxt = 1'b1;
                        state_nxt      = POINT;
                        cnt_nxt        = N_POINT;
                    end else if (nx + S_R > S_XMAX) begin
                        lscore_nxt     = sat_inc(lscore);
                        serve_left_nxt = 1'b0;
                        state_nxt      = POINT;
                        cnt_nxt        = N_POINT;
                    end
                end
            end
            POINT: begin
                if (tick) begin
                    if (cnt > 8'd1) begin
                        cnt_nxt = cnt - 8'd1;
                    end else if (lscore == WIN || rscore == WIN) begin
                        state_nxt = OVER;
                        cnt_nxt   = 8'd0;
                    end else begin
                        bx_nxt    = S_CX;
                        by_nxt    = S_CY;
                        speed_nxt = V0;
                        dy_nxt    = 1'b0;
                        dx_nxt    = serve_left;
                        state_nxt = SERVE;
                        cnt_nxt   = N_SERVE;
                    end
                end
            end
            OVER: begin
                if (tick && start) begin
                    lscore_nxt = 6'd0;
                    rscore_nxt = 6'd0;
                    bx_nxt     = S_CX;
                    by_nxt     = S_CY;
                    speed_nxt  = V0;
                    dy_nxt     = 1'b0;
                    dx_nxt     = serve_left;
                    state_nxt  = SERVE;
                    cnt_nxt    = N_SERVE;
                end
            end
            default: state_nxt = IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state      <= IDLE;
            cnt        <= 8'd0;
            ball_x     <= S_CX;
            ball_y     <= S_CY;
            dir_x      <= 1'b0;
            dir_y      <= 1'b0;
            speed      <= V0;
            serve_left <= 1'b0;
            lbar_y     <= S_CY;
            rbar_y     <= S_CY;
            lscore     <= 6'd0;
            rscore     <= 6'd0;
        end else begin
            state      <= state_nxt;
            cnt        <= cnt_nxt;
            ball_x     <= bx_nxt;
            ball_y     <= by_nxt;
            dir_x      <= dx_nxt;
            dir_y      <= dy_nxt;
            speed      <= speed_nxt;
            serve_left <= serve_left_nxt;
            lbar_y     <= lbar_nxt;
            rbar_y     <= rbar_nxt;
            lscore     <= lscore_nxt;
            rscore     <= rscore_nxt;
        end
    end

    assign xs      = signed'({1'b0, x});
    assign ys      = signed'({1'b0, y});
    assign y_div10 = y / 11'd10;
    assign y_div20 = y / 11'd20;

    // Later layers overwrite earlier ones, so the order below is the draw priority.
    always_comb begin
        pix = 8'd0;
        if (x < U_HA && y < U_VA) begin
            pix = C_BG;
            if ((y == U_TOP || y == U_BOT) && x >= U_LB && x <= U_RB)
                pix = (state == OVER) ? ((lscore == WIN) ? C_LEFT : C_RIGHT) : C_WALL;
            if (xs >= S_LB && xs <= S_LF && ys >= lbar_y - half_h && ys <= lbar_y + half_h)
                pix = C_LEFT;
            if (xs >= S_RF && xs <= S_RB && ys >= rbar_y - half_h && ys <= rbar_y + half_h)
                pix = C_RIGHT;
            if (state != IDLE && xs >= ball_x - S_R && xs <= ball_x + S_R &&
                ys >= ball_y - S_R && ys <= ball_y + S_R)
                pix = C_BALL;
            if (y_div10[0] && x >= 11'd10 && x <= 11'd20 && {5'd0, lscore} > y_div20)
                pix = C_LEFT;
            if (y_div10[0] && x >= PIP_R0 && x <= PIP_R1 && {5'd0, rscore} > y_div20)
                pix = C_RIGHT;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n)
            rgb <= 8'd0;
        else
            rgb <= pix;
    end

endmodule

// File: tb/tb_pong_engine.sv
// Directed bench for pong_engine: frames are single tick cycles, pixels probed one at a time.
module tb_pong_engine;

    localparam logic [7:0] C_BG    = 8'b01001000;
    localparam logic [7:0] C_WALL  = 8'b11100001;
    localparam logic [7:0] C_LEFT  = 8'b10010111;
    localparam logic [7:0] C_RIGHT = 8'b00101011;
    localparam logic [7:0] C_BALL  = 8'b11011101;

    logic        clk = 1'b0;
    logic        rst_n;
    logic [10:0] x, y;
    logic [1:0]  btn1, btn2;
    logic        start, wide_mode;
    logic [7:0]  rgb;
    logic [5:0]  lscore, rscore;
    logic        game_over;

    int n_cmp = 0;
    int n_bad = 0;

    pong_engine dut (
        .clk(clk), .rst_n(rst_n), .x(x), .y(y), .btn1(btn1), .btn2(btn2),
        .start(start), .wide_mode(wide_mode), .rgb(rgb), .lscore(lscore),
        .rscore(rscore), .game_over(game_over)
    );

    always #5 clk = ~clk;

    initial begin
        #5000000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1);
    end

    task automatic frame();
        @(negedge clk);
        x = 11'd0;
        y = 11'd0;
        @(negedge clk);
        x = 11'd700;
        y = 11'd500;
    endtask

    task automatic frames(input int n);
        for (int i = 0; i < n; i++) frame();
    endtask

    task automatic probe(input logic [10:0] px, input logic [10:0] py, output logic [7:0] c);
        @(negedge clk);
        x = px;
        y = py;
        @(negedge clk);
        c = rgb;
        x = 11'd700;
        y = 11'd500;
    endtask

    task automatic do_reset();
        @(negedge clk);
        rst_n = 1'b0;
        start = 1'b0; btn1 = 2'b00; btn2 = 2'b00; wide_mode = 1'b0;
        x = 11'd700; y = 11'd500;
        repeat (2) @(negedge clk);
        rst_n = 1'b1;
    endtask

    task automatic test_reset();
        logic [7:0] c;
        do_reset();
        n_cmp++;
        if (rgb !== 8'd0) begin n_bad++; $display("FAIL reset_rgb: got %b want 0", rgb); end
        frames(3);
        n_cmp++;
        if ({dut.ball_x, dut.ball_y} !== {12'd320, 12'd240}) begin
            n_bad++; $display("FAIL idle_ball: got (%0d,%0d) want (320,240)", dut.ball_x, dut.ball_y);
        end
        n_cmp++;
        if ({dut.state, lscore, rscore, game_over} !== {3'd0, 6'd0, 6'd0, 1'b0}) begin
            n_bad++; $display("FAIL idle_state: state %0d l %0d r %0d go %b want 0 0 0 0",
                              dut.state, lscore, rscore, game_over);
        end
        probe(11'd320, 11'd240, c);
        n_cmp++;
        if (c !== C_BG) begin n_bad++; $display("FAIL idle_centre_pix: got %b want %b", c, C_BG); end
        probe(11'd640, 11'd10, c);
        n_cmp++;
        if (c !== 8'd0) begin n_bad++; $display("FAIL offscreen_pix: got %b want 0", c); end
        probe(11'd100, 11'd40, c);
        n_cmp++;
        if (c !== C_WALL) begin n_bad++; $display("FAIL wall_pix: got %b want %b", c, C_WALL); end
    endtask

    task automatic test_serve_hit();
        logic [7:0] c;
        btn2 = 2'b10;
        start = 1'b1;
        frame();
        start = 1'b0;
        frames(60);
        n_cmp++;
        if ({dut.state, dut.ball_x, dut.ball_y} !== {3'd2, 12'd320, 12'd240}) begin
            n_bad++; $display("FAIL serve_release: state %0d ball (%0d,%0d) want 2 (320,240)",
                              dut.state, dut.ball_x, dut.ball_y);
        end
        frames(10);
        btn2 = 2'b00;
        frames(240);
        n_cmp++;
        if ({dut.ball_x, dut.ball_y, dut.dir_x} !== {12'd570, 12'd380, 1'b0}) begin
            n_bad++; $display("FAIL pre_hit: ball (%0d,%0d) dx %b want (570,380) 0",
                              dut.ball_x, dut.ball_y, dut.dir_x);
        end
        frame();
        n_cmp++;
        if ({dut.ball_x, dut.ball_y, dut.dir_x, dut.speed} !== {12'd570, 12'd379, 1'b1, 3'd2}) begin
            n_bad++; $display("FAIL right_hit: ball (%0d,%0d) dx %b spd %0d want (570,379) 1 2",
                              dut.ball_x, dut.ball_y, dut.dir_x, dut.speed);
        end
        n_cmp++;
        if (dut.rbar_y !== 12'd380) begin n_bad++; $display("FAIL rbar_move: got %0d want 380", dut.rbar_y); end
        probe(11'd570, 11'd379, c);
        n_cmp++;
        if (c !== C_BALL) begin n_bad++; $display("FAIL ball_pix: got %b want %b", c, C_BALL); end
        probe(11'd577, 11'd380, c);
        n_cmp++;
        if (c !== C_RIGHT) begin n_bad++; $display("FAIL rpad_pix: got %b want %b", c, C_RIGHT); end
    endtask

    task automatic test_paddles();
        logic [7:0] c;
        btn1 = 2'b11;
        frames(100);
        n_cmp++;
        if (dut.lbar_y !== 12'd240) begin n_bad++; $display("FAIL both_buttons: got %0d want 240", dut.lbar_y); end
        btn1 = 2'b01;
        frames(90);
        n_cmp++;
        if (dut.lbar_y !== 12'd70) begin n_bad++; $display("FAIL lbar_top_clamp: got %0d want 70", dut.lbar_y); end
        btn1 = 2'b00;
        wide_mode = 1'b1;
        frame();
        n_cmp++;
        if ({dut.lbar_y, dut.rbar_y} !== {12'd115, 12'd365}) begin
            n_bad++; $display("FAIL wide_clamp: l %0d r %0d want 115 365", dut.lbar_y, dut.rbar_y);
        end
        probe(11'd62, 11'd190, c);
        n_cmp++;
        if (c !== C_LEFT) begin n_bad++; $display("FAIL wide_edge_pix: got %b want %b", c, C_LEFT); end
        probe(11'd62, 11'd191, c);
        n_cmp++;
        if (c !== C_BG) begin n_bad++; $display("FAIL below_pad_pix: got %b want %b", c, C_BG); end
        wide_mode = 1'b0;
    endtask

    task automatic test_point();
        do_reset();
        btn2 = 2'b01;
        start = 1'b1;
        frame();
        start = 1'b0;
        frames(60 + 315);
        n_cmp++;
        if ({dut.state, lscore, rscore} !== {3'd3, 6'd1, 6'd0}) begin
            n_bad++; $display("FAIL left_point: state %0d l %0d r %0d want 3 1 0", dut.state, lscore, rscore);
        end
        frames(29);
        n_cmp++;
        if ({dut.state, dut.ball_x, dut.ball_y} !== {3'd3, 12'd635, 12'd315}) begin
            n_bad++; $display("FAIL point_freeze: state %0d ball (%0d,%0d) want 3 (635,315)",
                              dut.state, dut.ball_x, dut.ball_y);
        end
        frame();
        n_cmp++;
        if ({dut.state, dut.ball_x, dut.ball_y, dut.dir_x, dut.dir_y, dut.speed} !==
            {3'd1, 12'd320, 12'd240, 1'b0, 1'b0, 3'd1}) begin
            n_bad++; $display("FAIL reserve: state %0d ball (%0d,%0d) dx %b dy %b spd %0d want 1 (320,240) 0 0 1",
                              dut.state, dut.ball_x, dut.ball_y, dut.dir_x, dut.dir_y, dut.speed);
        end
    endtask

    task automatic test_win();
        logic [7:0] c;
        for (int p = 2; p <= 9; p++) begin
            frames(60 + 315);
            n_cmp++;
            if (lscore !== 6'(p)) begin n_bad++; $display("FAIL score_step: got %0d want %0d", lscore, p); end
            frames(30);
        end
        n_cmp++;
        if ({dut.state, game_over, rscore} !== {3'd4, 1'b1, 6'd0}) begin
            n_bad++; $display("FAIL game_over: state %0d go %b r %0d want 4 1 0", dut.state, game_over, rscore);
        end
        probe(11'd100, 11'd40, c);
        n_cmp++;
        if (c !== C_LEFT) begin n_bad++; $display("FAIL winner_line: got %b want %b", c, C_LEFT); end
        probe(11'd15, 11'd170, c);
        n_cmp++;
        if (c !== C_LEFT) begin n_bad++; $display("FAIL pip_lit: got %b want %b", c, C_LEFT); end
        probe(11'd15, 11'd180, c);
        n_cmp++;
        if (c !== C_BG) begin n_bad++; $display("FAIL pip_even_row: got %b want %b", c, C_BG); end
        probe(11'd15, 11'd190, c);
        n_cmp++;
        if (c !== C_BG) begin n_bad++; $display("FAIL pip_above_score: got %b want %b", c, C_BG); end
        start = 1'b1;
        frame();
        start = 1'b0;
        n_cmp++;
        if ({dut.state, lscore, rscore, game_over} !== {3'd1, 6'd0, 6'd0, 1'b0}) begin
            n_bad++; $display("FAIL restart: state %0d l %0d r %0d go %b want 1 0 0 0",
                              dut.state, lscore, rscore, game_over);
        end
    endtask

    task automatic test_reset_mid_play();
        do_reset();
        btn2 = 2'b10;
        start = 1'b1;
        frame();
        start = 1'b0;
        frames(70);
        btn2 = 2'b00;
        frames(492);
        n_cmp++;
        if ({dut.ball_x, dut.ball_y, dut.dir_x, dut.speed} !== {12'd70, 12'd213, 1'b0, 3'd3}) begin
            n_bad++; $display("FAIL left_hit: ball (%0d,%0d) dx %b spd %0d want (70,213) 0 3",
                              dut.ball_x, dut.ball_y, dut.dir_x, dut.speed);
        end
        frame();
        n_cmp++;
        if ({dut.ball_x, dut.ball_y} !== {12'd73, 12'd216}) begin
            n_bad++; $display("FAIL speed3_step: ball (%0d,%0d) want (73,216)", dut.ball_x, dut.ball_y);
        end
        @(negedge clk);
        x = 11'd73;
        y = 11'd216;
        @(posedge clk);
        #2;
        n_cmp++;
        if (rgb !== C_BALL) begin n_bad++; $display("FAIL pre_reset_pix: got %b want %b", rgb, C_BALL); end
        rst_n = 1'b0;
        #1;
        n_cmp++;
        if ({rgb, lscore, rscore, game_over} !== {8'd0, 6'd0, 6'd0, 1'b0}) begin
            n_bad++; $display("FAIL async_reset_out: rgb %b l %0d r %0d go %b want 0 0 0 0",
                              rgb, lscore, rscore, game_over);
        end
        n_cmp++;
        if ({dut.state, dut.ball_x, dut.ball_y, dut.speed} !== {3'd0, 12'd320, 12'd240, 3'd1}) begin
            n_bad++; $display("FAIL async_reset_state: state %0d ball (%0d,%0d) spd %0d want 0 (320,240) 1",
                              dut.state, dut.ball_x, dut.ball_y, dut.speed);
        end
        @(negedge clk);
        x = 11'd700;
        y = 11'd500;
        @(negedge clk);
        rst_n = 1'b1;
        frames(3);
        n_cmp++;
        if (dut.state !== 3'd0) begin n_bad++; $display("FAIL stay_idle: got %0d want 0", dut.state); end
        start = 1'b1;
        frame();
        start = 1'b0;
        n_cmp++;
        if (dut.state !== 3'd1) begin n_bad++; $display("FAIL resume_serve: got %0d want 1", dut.state); end
    endtask

    initial begin
        rst_n = 1'b0;
        x = 11'd700; y = 11'd500;
        btn1 = 2'b00; btn2 = 2'b00;
        start = 1'b0; wide_mode = 1'b0;
        test_reset();
        test_serve_hit();
        test_paddles();
        test_point();
        test_win();
        test_reset_mid_play();
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule
